// File: rtl/agc_sequencer.sv
// Packet AGC sequencer: averages RSSI, steps the front-end gain index toward the
// set point, and locks on deadband, gain clamp or iteration limit.
module agc_sequencer #(
    parameter int RSSI_WIDTH      = 16,
    parameter int GAIN_WIDTH      = 5,
    parameter int NUM_GAIN_LEVELS = 17,
    parameter int INIT_GAIN       = 8,
    parameter int SET_POINT_DBFS  = -2304,
    parameter int DEADBAND        = 256,
    parameter int AVG_SHIFT       = 3,
    parameter int STEP_SHIFT      = 9,
    parameter int SETTLE_CYCLES   = 16,
    parameter int MAX_ITER        = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pkt_detect,
    input  logic                         pkt_end,
    input  logic signed [RSSI_WIDTH-1:0] rssi_dbfs,
    input  logic                         rssi_valid,
    output logic [GAIN_WIDTH-1:0]        gain_word,
    output logic                         gain_update,
    output logic                         agc_busy,
    output logic                         agc_locked,
    output logic                         sat_flag,
    output logic                         timeout_flag,
    output logic [3:0]                   iter_count
);

    localparam int ACC_WIDTH    = RSSI_WIDTH + AVG_SHIFT;
    localparam int ERR_WIDTH    = RSSI_WIDTH + 1;
    localparam int CALC_WIDTH   = ERR_WIDTH + GAIN_WIDTH + 1;
    localparam int SCNT_WIDTH   = AVG_SHIFT + 1;
    localparam int SETTLE_WIDTH = $clog2(SETTLE_CYCLES + 1);

    localparam logic [GAIN_WIDTH-1:0]        INIT_GAIN_W = GAIN_WIDTH'(INIT_GAIN);
    localparam logic signed [ERR_WIDTH-1:0]  SET_POINT_E = ERR_WIDTH'(SET_POINT_DBFS);
    localparam logic [ERR_WIDTH-1:0]         DEADBAND_E  = ERR_WIDTH'(DEADBAND);
    localparam logic signed [CALC_WIDTH-1:0] GAIN_MAX_C  = CALC_WIDTH'(NUM_GAIN_LEVELS - 1);
    localparam logic [SCNT_WIDTH-1:0]        LAST_SAMPLE = SCNT_WIDTH'((1 << AVG_SHIFT) - 1);
    localparam logic [SETTLE_WIDTH-1:0]      LAST_SETTLE = SETTLE_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [3:0]                   MAX_ITER_C  = 4'(MAX_ITER);

    typedef enum logic [2:0] {
        IDLE,
        MEASURE,
        ADJUST,
        SETTLE,
        LOCKED
    } state_e;

    state_e                        state_q, state_d;
    logic [GAIN_WIDTH-1:0]         gain_q, gain_d;
    logic                          gain_update_q, gain_update_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [SCNT_WIDTH-1:0]         sample_cnt_q, sample_cnt_d;
    logic [SETTLE_WIDTH-1:0]       settle_cnt_q, settle_cnt_d;
    logic [3:0]                    iter_q, iter_d;
    logic                          sat_q, sat_d;
    logic                          timeout_q, timeout_d;

    logic signed [ACC_WIDTH-1:0]   rssi_ext;
    logic signed [RSSI_WIDTH-1:0]  avg;
    logic signed [ERR_WIDTH-1:0]   err;
    logic                          err_neg;
    logic [ERR_WIDTH-1:0]          err_abs;
    logic [ERR_WIDTH-1:0]          step_raw;
    logic [ERR_WIDTH-1:0]          step_mag;
    logic [CALC_WIDTH-1:0]         gain_ext;
    logic [CALC_WIDTH-1:0]         step_ext;
    logic signed [CALC_WIDTH-1:0]  gain_sum;
    logic [GAIN_WIDTH-1:0]         new_gain;
    logic                          in_deadband;

    // Averaging is a floor division, so the shifted accumulator slice is the mean.
    assign rssi_ext    = {{AVG_SHIFT{rssi_dbfs[RSSI_WIDTH-1]}}, rssi_dbfs};
    assign avg         = acc_q[AVG_SHIFT +: RSSI_WIDTH];
    assign err         = SET_POINT_E - {avg[RSSI_WIDTH-1], avg};
    assign err_neg     = err[ERR_WIDTH-1];
    assign err_abs     = err_neg ? -err : err;
    assign in_deadband = (err_abs <= DEADBAND_E);
    assign step_raw    = err_abs >> STEP_SHIFT;
    assign step_mag    = (step_raw == '0) ? ERR_WIDTH'(1) : step_raw;
    assign gain_ext    = {{(CALC_WIDTH - GAIN_WIDTH){1'b0}}, gain_q};
    assign step_ext    = {{(CALC_WIDTH - ERR_WIDTH){1'b0}}, step_mag};
    assign gain_sum    = err_neg ? (gain_ext - step_ext) : (gain_ext + step_ext);

    always_comb begin
        new_gain = gain_sum[GAIN_WIDTH-1:0];
        if (gain_sum[CALC_WIDTH-1]) begin
            new_gain = '0;
        end else if (gain_sum > GAIN_MAX_C) begin
            new_gain = GAIN_MAX_C[GAIN_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d       = state_q;
        gain_d        = gain_q;
        gain_update_d = 1'b0;
        acc_d         = acc_q;
        sample_cnt_d  = sample_cnt_q;
        settle_cnt_d  = settle_cnt_q;
        iter_d        = iter_q;
        sat_d         = sat_q;
        timeout_d     = timeout_q;

        // Packet end aborts from any active state; iteration count and flags survive.
        if (pkt_end && (state_q != IDLE)) begin
            state_d      = IDLE;
            acc_d        = '0;
            sample_cnt_d = '0;
            settle_cnt_d = '0;
            if (gain_q != INIT_GAIN_W) begin
                gain_d        = INIT_GAIN_W;
                gain_update_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    acc_d        = '0;
                    sample_cnt_d = '0;
                    settle_cnt_d = '0;
                    if (pkt_detect && !pkt_end) begin
                        state_d   = MEASURE;
                        iter_d    = '0;
                        sat_d     = 1'b0;
                        timeout_d = 1'b0;
                    end
                end
                MEASURE: begin
                    if (rssi_valid) begin
                        acc_d        = acc_q + rssi_ext;
                        sample_cnt_d = sample_cnt_q + 1'b1;
                        if (sample_cnt_q == LAST_SAMPLE) begin
                            state_d = ADJUST;
                        end
                    end
                end
                ADJUST: begin
                    if (in_deadband) begin
                        state_d   = LOCKED;
                        sat_d     = 1'b0;
                        timeout_d = 1'b0;
                    end else if (iter_q == MAX_ITER_C) begin
                        state_d   = LOCKED;
                        timeout_d = 1'b1;
                    end else if (new_gain == gain_q) begin
                        state_d = LOCKED;
                        sat_d   = 1'b1;
                    end else begin
                        state_d       = SETTLE;
                        gain_d        = new_gain;
                        gain_update_d = 1'b1;
                        iter_d        = (iter_q == 4'hF) ? iter_q : iter_q + 4'd1;
                        acc_d         = '0;
                        sample_cnt_d  = '0;
                        settle_cnt_d  = '0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt_q == LAST_SETTLE) begin
                        state_d      = MEASURE;
                        settle_cnt_d = '0;
                        acc_d        = '0;
                        sample_cnt_d = '0;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 1'b1;
                    end
                end
                LOCKED: begin
                    state_d = LOCKED;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            gain_q        <= INIT_GAIN_W;
            gain_update_q <= 1'b0;
            acc_q         <= '0;
            sample_cnt_q  <= '0;
            settle_cnt_q  <= '0;
            iter_q        <= '0;
            sat_q         <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            gain_q        <= gain_d;
            gain_update_q <= gain_update_d;
            acc_q         <= acc_d;
            sample_cnt_q  <= sample_cnt_d;
            settle_cnt_q  <= settle_cnt_d;
            iter_q        <= iter_d;
            sat_q         <= sat_d;
            timeout_q     <= timeout_d;
        end
    end

    assign gain_word    = gain_q;
    assign gain_update  = gain_update_q;
    assign agc_busy     = (state_q == MEASURE) || (state_q == ADJUST) || (state_q == SETTLE);
    assign agc_locked   = (state_q == LOCKED);
    assign sat_flag     = sat_q;
    assign timeout_flag = timeout_q;
    assign iter_count   = iter_q;

endmodule

// File: tb/tb_agc_sequencer.sv
// Directed bench for agc_sequencer: a table of measurement windows with
// hand-computed gain decisions, then pkt_end, IDLE and reset corner sequences.
module tb_agc_sequencer;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pkt_detect;
    logic              pkt_end;
    logic signed [15:0] rssi_dbfs;
    logic              rssi_valid;
    logic [4:0]        gain_word;
    logic              gain_update;
    logic              agc_busy;
    logic              agc_locked;
    logic              sat_flag;
    logic              timeout_flag;
    logic [3:0]        iter_count;

    int compared   = 0;
    int mismatched = 0;

    int curGain = 8;
    int curIter = 0;
    bit curSat  = 1'b0;
    bit curTmo  = 1'b0;

    typedef struct {
        bit newPkt;
        bit gaps;
        int rssi;
        int expGain;
        bit expUpd;
        bit expLocked;
        bit expSat;
        bit expTmo;
        int expIter;
    } vec_t;

    vec_t vecs[$];

    agc_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pkt_detect   (pkt_detect),
        .pkt_end      (pkt_end),
        .rssi_dbfs    (rssi_dbfs),
        .rssi_valid   (rssi_valid),
        .gain_word    (gain_word),
        .gain_update  (gain_update),
        .agc_busy     (agc_busy),
        .agc_locked   (agc_locked),
        .sat_flag     (sat_flag),
        .timeout_flag (timeout_flag),
        .iter_count   (iter_count)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input bit pd, input bit pe, input bit v, input int r);
        pkt_detect = pd;
        pkt_end    = pe;
        rssi_valid = v;
        rssi_dbfs  = 16'(r);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int g, input bit u, input bit b,
                               input bit l, input bit s, input bit t, input int it);
        logic [13:0] got;
        logic [13:0] exp;
        got = {gain_word, gain_update, agc_busy, agc_locked, sat_flag, timeout_flag, iter_count};
        exp = {5'(g), u, b, l, s, t, 4'(it)};
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got gain=%0d upd=%0b busy=%0b locked=%0b sat=%0b tmo=%0b iter=%0d, expected gain=%0d upd=%0b busy=%0b locked=%0b sat=%0b tmo=%0b iter=%0d",
                     name, gain_word, gain_update, agc_busy, agc_locked, sat_flag, timeout_flag,
                     iter_count, g, u, b, l, s, t, it);
        end
    endtask

    // Ends any current packet (restoring the initial gain) and starts a fresh one.
    task automatic startPacket();
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        checkOutput("pkt_end flush", 8, (curGain != 8), 1'b0, 1'b0, curSat, curTmo, curIter);
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        checkOutput("pkt_detect start", 8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        curGain = 8;
        curIter = 0;
        curSat  = 1'b0;
        curTmo  = 1'b0;
    endtask

    task automatic runWindow(input int r, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps) applyStimulus(1'b0, 1'b0, 1'b0, 32767);
            applyStimulus(1'b0, 1'b0, 1'b1, r);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int updCount;

        vecs.push_back('{1'b1, 1'b0, -2304,  8, 1'b0, 1'b1, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 1'b0, -3840, 11, 1'b1, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b0, 1'b0, -2304, 11, 1'b0, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b1, 1'b0, -10240, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b0, 1'b0, -10240, 16, 1'b0, 1'b1, 1'b1, 1'b0, 1});
        vecs.push_back('{1'b1, 1'b0, -6000, 15, 1'b1, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b0, 1'b0,  -200, 11, 1'b1, 1'b0, 1'b0, 1'b0, 2});
        vecs.push_back('{1'b0, 1'b0, -6000, 16, 1'b1, 1'b0, 1'b0, 1'b0, 3});
        vecs.push_back('{1'b0, 1'b0,  -200, 12, 1'b1, 1'b0, 1'b0, 1'b0, 4});
        vecs.push_back('{1'b0, 1'b0, -6000, 12, 1'b0, 1'b1, 1'b0, 1'b1, 4});
        vecs.push_back('{1'b1, 1'b1, -2604,  9, 1'b1, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b0, 1'b0, -2048,  9, 1'b0, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b1, 1'b0, -2004,  7, 1'b1, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b0, 1'b1, -2560,  7, 1'b0, 1'b1, 1'b0, 1'b0, 1});

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
        checkOutput("reset state", 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            if (vecs[k].newPkt) startPacket();
            runWindow(vecs[k].rssi, vecs[k].gaps);
            applyStimulus(1'b0, 1'b0, 1'b1, 32767);
            checkOutput($sformatf("vec%0d adjust", k), vecs[k].expGain, vecs[k].expUpd,
                        !vecs[k].expLocked, vecs[k].expLocked, vecs[k].expSat,
                        vecs[k].expTmo, vecs[k].expIter);
            curGain = vecs[k].expGain;
            curIter = vecs[k].expIter;
            curSat  = vecs[k].expSat;
            curTmo  = vecs[k].expTmo;
            if (!vecs[k].expLocked) begin
                applyStimulus(1'b0, 1'b0, 1'b1, 32767);
                checkOutput($sformatf("vec%0d settle", k), vecs[k].expGain, 1'b0, 1'b1,
                            1'b0, 1'b0, 1'b0, vecs[k].expIter);
                repeat (15) applyStimulus(1'b0, 1'b0, 1'b1, 32767);
            end
        end

        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        checkOutput("detect ignored in LOCKED", 7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);

        startPacket();
        runWindow(-3840, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
        checkOutput("abort run adjust", 11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, -2304);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        checkOutput("pkt_end in SETTLE", 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        updCount = 0;
        repeat (4) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 0);
            if (gain_update) updCount++;
        end
        compared++;
        if (updCount != 0) begin
            mismatched++;
            $display("[TB] FAIL extra gain_update: got %0d further pulses, expected 0", updCount);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 0);
        checkOutput("detect+end in IDLE", 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
        checkOutput("still IDLE", 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        curGain = 8;
        curIter = 1;
        curSat  = 1'b0;
        curTmo  = 1'b0;

        startPacket();
        runWindow(-3840, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
        checkOutput("pre-reset adjust", 11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        repeat (16) applyStimulus(1'b0, 1'b0, 1'b0, 0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, -3840);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
        checkOutput("reset mid MEASURE", 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
        checkOutput("after reset release", 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        curGain = 8;
        curIter = 0;

        startPacket();
        runWindow(-2304, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32767);
        checkOutput("post-reset lock", 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
